fir_mac_scheduler: RTL and testbench

- Time-multiplexed FIR controller: one multiplier/accumulator shared across all taps, sequenced by a per-sample state machine.
- Replaces the fully parallel 24-tap MAC array where DSP slices are scarce.
- Accepts samples over valid/ready and returns filtered results over valid/ready.
- Double-banked coefficient store, reloadable at run time, with bank swap only between samples.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_mac_scheduler_if.sv | 28 ++
 rtl/fir_coef_bank.sv | 47 ++++
 rtl/fir_mac_scheduler.sv | 157 +++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR scheduler.
//   NTAPS_DEFAULT / DATA_W / COEF_W / ACC_W : default filter geometry
//   TAP_AW                                  : tap index width for the default geometry
//   state_t                                 : per-sample sequencer states
//   tap_addr()                              : circular delay-line address of tap k
package fir_pkg;

    localparam int NTAPS_DEFAULT = 24;
    localparam int DATA_W        = 16;
    localparam int COEF_W        = 16;
    localparam int ACC_W         = 32;
    localparam int TAP_AW        = $clog2(NTAPS_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Entry holding x[n-k] when the newest sample sits at wp.
    // The wrap is explicit so a non power-of-two NTAPS still works.
    function automatic int tap_addr(input int wp, input int k, input int ntaps);
        return (wp >= k) ? (wp - k) : (wp + ntaps - k);
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample/result stream bundle for fir_mac_scheduler.
//   in_valid/in_ready/x_in     : sample stream into the filter
//   out_valid/out_ready/y_out  : result stream out of the filter
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender holds valid and data stable until that edge; ready
// may change freely and never depends combinationally on valid.
// slave = filter view, master = upstream/downstream environment view.
interface fir_mac_scheduler_if #(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int ACC_W  = fir_pkg::ACC_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  y_out;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, y_out
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, y_out
    );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-banked coefficient store.
//   clk, rst  : clock, asynchronous active-high reset (clears both banks, sel=0)
//   wr_en     : write wr_data into the shadow bank at wr_addr (>= NTAPS ignored)
//   swap      : make the shadow bank active on this edge
//   rd_addr   : tap index read combinationally from the active bank
//   rd_data   : active coefficient
module fir_coef_bank #(
    parameter int NTAPS  = fir_pkg::NTAPS_DEFAULT,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int AW     = fir_pkg::TAP_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic                     swap,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [COEF_W-1:0] rd_data
);

    logic signed [COEF_W-1:0] bank [2][NTAPS];
    logic                     sel;

    // A write and a swap on the same edge both use the old sel, so the
    // written value lands in the bank that becomes active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NTAPS; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            if (wr_en && (int'(wr_addr) < NTAPS)) begin
                bank[~sel][wr_addr] <= wr_data;
            end
            if (swap) begin
                sel <= ~sel;
            end
        end
    end

    assign rd_data = bank[sel][rd_addr];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR filter: one shared multiply-accumulate walks all taps
// for each accepted sample, then presents the result.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : sample in / result out streams (slave modport)
//   coef_wr_en    : write coef_data to shadow coefficient at coef_addr
//   coef_addr     : tap index, values >= NTAPS ignored
//   coef_data     : signed coefficient
//   coef_swap     : one-cycle request to activate the shadow bank
//   swap_pending  : swap requested but not yet applied
//   busy          : sequencer not in IDLE
//   state_dbg     : current sequencer state
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int NTAPS  = fir_pkg::NTAPS_DEFAULT,
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int ACC_W  = fir_pkg::ACC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    fir_mac_scheduler_if.slave         bus,
    input  logic                       coef_wr_en,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       coef_swap,
    output logic                       swap_pending,
    output logic                       busy,
    output state_t                     state_dbg
);

    localparam int AW = $clog2(NTAPS);
    localparam int PW = DATA_W + COEF_W;

    state_t state, state_n;

    logic signed [DATA_W-1:0] dline [NTAPS];
    logic [AW-1:0]            wp;
    logic [AW-1:0]            wp_next;
    logic [AW-1:0]            k;
    logic [AW-1:0]            rd_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  y_q;
    logic signed [COEF_W-1:0] coef_rd;
    logic signed [PW-1:0]     prod;
    logic                     pending_q;
    logic                     apply_swap;
    logic                     last_tap;

    // Swap is taken only between samples; in IDLE it happens on the request
    // edge itself so a sample accepted on that edge already sees the new bank.
    assign apply_swap = (state == IDLE) && (pending_q || coef_swap);
    assign wp_next    = (wp == AW'(NTAPS - 1)) ? '0 : wp + AW'(1);
    assign rd_idx     = AW'(tap_addr(int'(wp), int'(k), NTAPS));
    assign last_tap   = (k == AW'(NTAPS - 1));

    fir_coef_bank #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .AW     (AW)
    ) u_coef (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coef_wr_en),
        .wr_addr (coef_addr),
        .wr_data (coef_data),
        .swap    (apply_swap),
        .rd_addr (k),
        .rd_data (coef_rd)
    );

    // Full-precision product, then sign-extended or truncated to ACC_W.
    assign prod = dline[rd_idx] * coef_rd;
    assign sum  = acc + ACC_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_n = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                dline[i] <= '0;
            end
            wp        <= '0;
            k         <= '0;
            acc       <= '0;
            y_q       <= '0;
            pending_q <= 1'b0;
        end else begin
            if (apply_swap) begin
                pending_q <= 1'b0;
            end else if (coef_swap) begin
                pending_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dline[wp_next] <= bus.x_in;
                        wp             <= wp_next;
                        acc            <= '0;
                        k              <= '0;
                    end
                end
                MAC: begin
                    acc <= sum;
                    k   <= k + AW'(1);
                    // Result register is separate from acc so y_out holds
                    // after the handshake while the next sample accumulates.
                    if (last_tap) begin
                        y_q <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.y_out    = y_q;
    assign swap_pending = pending_q;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
module tb_fir_mac_scheduler;
  import fir_pkg::*;

  localparam int NT = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_wr_en = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_swap = 1'b0;
  logic        swap_pending;
  logic        busy;
  state_t      state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] y;
  logic        saw_valid;

  fir_mac_scheduler_if #(.DATA_W(16), .ACC_W(32)) bus ();

  fir_mac_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .coef_wr_en   (coef_wr_en),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .coef_swap    (coef_swap),
    .swap_pending (swap_pending),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input int a, input logic [15:0] d);
    coef_wr_en = 1'b1;
    coef_addr  = 5'(a);
    coef_data  = d;
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
  endtask

  task automatic start_sample(input logic [15:0] x);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // waits for the result; with out_ready high the final tick completes the handshake
  task automatic wait_result(output logic [31:0] yv);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("out_valid_wait", 32'(bus.out_valid), 32'd1);
    yv = bus.y_out;
    tick();
  endtask

  task automatic send(input logic [15:0] x, output logic [31:0] yv);
    start_sample(x);
    wait_result(yv);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y_out", bus.y_out, 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // impulse response with b[k] = k+1
    for (int i = 0; i < NT; i++) write_coef(i, 16'(i + 1));
    pulse_swap();
    check("idle_swap_immediate", 32'(swap_pending), 32'd0);
    for (int i = 0; i < 30; i++) begin
      send((i == 0) ? 16'd1 : 16'd0, y);
      check($sformatf("impulse_%0d", i), y, (i < NT) ? 32'(i + 1) : 32'd0);
    end

    // latency and backpressure: buffer holds only the new 2, so y = 2*b[0] = 2
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x_in      = 16'd2;
    for (int j = 1; j <= 25; j++) begin
      tick();
      bus.in_valid = 1'b0;
      if (j == 1) check("lat_in_ready_low", 32'(bus.in_ready), 32'd0);
      if (j == 24) check("lat_no_early_valid", 32'(bus.out_valid), 32'd0);
      if (j == 25) check("lat_valid_at_25", 32'(bus.out_valid), 32'd1);
    end
    for (int j = 0; j < 5; j++) begin
      check("bp_y_hold", bus.y_out, 32'd2);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle_after", 32'(state_dbg), 32'(IDLE));
    check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    check("bp_y_kept", bus.y_out, 32'd2);

    // wrap: 32767*32767 + 2*32767 then 24*32767^2 mod 2^32
    for (int i = 0; i < NT; i++) write_coef(i, 16'h7FFF);
    pulse_swap();
    for (int i = 0; i < NT; i++) begin
      send(16'h7FFF, y);
      if (i == 0) check("wrap_first", y, 32'h3FFF_FFFF);
      if (i == NT - 1) check("wrap_full", y, 32'hFFE8_0018);
    end

    // negative extremes: 12 pairs of 2^30 - 32767*32768 = 12*32768, then 24*2^30 mod 2^32 = 0
    for (int i = 0; i < NT; i++) write_coef(i, 16'h8000);
    pulse_swap();
    for (int i = 0; i < NT; i++) begin
      send(16'h8000, y);
      if (i == 11) check("neg_half", y, 32'h0006_0000);
      if (i == NT - 1) check("neg_full", y, 32'h0000_0000);
    end

    // mid-sample swap: shadow gets b[0]=3, rest 0
    write_coef(0, 16'd3);
    for (int i = 1; i < NT; i++) write_coef(i, 16'd0);
    start_sample(16'd1);
    tick();
    tick();
    pulse_swap();
    check("mid_pending", 32'(swap_pending), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    pulse_swap();
    check("mid_pending_repeat", 32'(swap_pending), 32'd1);
    wait_result(y);
    check("mid_old_bank", y, 32'hBFFF_8000);
    check("mid_pending_in_idle", 32'(swap_pending), 32'd1);
    start_sample(16'd7);
    check("mid_pending_cleared", 32'(swap_pending), 32'd0);
    wait_result(y);
    check("mid_new_bank", y, 32'd21);

    // reset mid-MAC with a swap pending
    start_sample(16'd5);
    pulse_swap();
    repeat (9) tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_pending", 32'(swap_pending), 32'd0);
    check("rmid_y", bus.y_out, 32'd0);
    saw_valid = 1'b0;
    for (int j = 0; j < 30; j++) begin
      saw_valid = saw_valid | bus.out_valid;
      tick();
    end
    check("rmid_no_output", 32'(saw_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send((i == 0) ? 16'd1 : 16'd0, y);
      check($sformatf("rmid_zero_coef_%0d", i), y, 32'd0);
    end

    // same-cycle write + swap in IDLE
    coef_wr_en = 1'b1;
    coef_addr  = 5'd0;
    coef_data  = 16'd5;
    coef_swap  = 1'b1;
    tick();
    coef_wr_en = 1'b0;
    coef_swap  = 1'b0;
    check("ws_pending", 32'(swap_pending), 32'd0);
    send(16'd1, y);
    check("ws_first", y, 32'd5);
    send(16'd0, y);
    check("ws_second", y, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
